seg_reader: RTL and testbench
=============================

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed display digits (1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (1..255).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port seg_in  input  7  segment pattern, active-low, bit0=a .. bit6=g (0 = segment lit).
REQ-006 SHALL have port dig_sel  input  DIGITS  digit strobe, active-high, one-hot when valid.
REQ-007 SHALL have port out_ready  input  1  consumer accepts frame.
REQ-008 SHALL have port value  output  4*DIGITS  decoded nibbles, digit i at bits [4i+3:4i].
REQ-009 SHALL have port err_mask  output  DIGITS  bit i set = digit i pattern unrecognised.
REQ-010 SHALL have port out_valid  output  1  complete frame held on value/err_mask.
REQ-011 SHALL have port busy  output  1  at least one digit captured, frame incomplete.

Function
REQ-012 SHALL register seg_in and dig_sel once per clock; all decisions use the registered samples.
REQ-013 SHALL use states COLLECT and PRESENT only.
REQ-014 In COLLECT, the stability counter SHALL increment (saturating at STABLE_CYCLES) when the current sample equals the previous sample and dig_sel is one-hot; otherwise it SHALL clear to 0.
REQ-015 All-zero or multi-hot dig_sel SHALL clear the counter and SHALL never capture.
REQ-016 When the counter reaches STABLE_CYCLES-1 and the slot is not yet captured, the slot SHALL be captured that cycle: nibble written, err bit written, captured bit set.
REQ-017 An already-captured slot SHALL NOT be overwritten within the same frame.
REQ-018 Decode SHALL be the exact inverse of the team hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (g..a).
REQ-019 Any other pattern SHALL store nibble 0 and set the err bit.
REQ-020 When all DIGITS captured bits are set, the FSM SHALL enter PRESENT on the next clock, and out_valid SHALL rise in that cycle.
REQ-021 In PRESENT, value/err_mask SHALL be held stable, inputs ignored, counter held at 0.
REQ-022 On out_valid && out_ready, the FSM SHALL return to COLLECT next cycle with all captured bits cleared; value/err_mask keep their last contents until overwritten.
REQ-023 busy SHALL equal (state==COLLECT) && (captured bits != 0).

Reset
REQ-024 resetn low SHALL asynchronously force: state COLLECT, counter 0, captured bits 0, value 0, err_mask 0, out_valid 0, busy 0, sample registers 0.
REQ-025 Reset mid-frame or mid-PRESENT SHALL discard the partial/pending frame with no output handshake.

Configuration
REQ-026 With SEG_READER_BLANK_EN defined, pattern 1111111 (all off) SHALL decode as a valid blank: nibble 0, err bit 0, blank_mask output (DIGITS wide, reset 0) bit set; without it, 1111111 SHALL be treated as invalid per REQ-019 and blank_mask SHALL not exist.

Structure
REQ-027 Package seg_pkg SHALL hold the 16 segment-pattern constants, the blank constant and the state enum typedef.
REQ-028 Pattern-to-nibble decode SHALL be a combinational sub-module seg_to_nibble (inputs pattern; outputs nibble, invalid, blank).

Verification
REQ-029 Scan 4 digits 3,A,7,F each held 6 cycles, STABLE_CYCLES=4 -> out_valid rises, value=16'hF7A3, err_mask=0.
REQ-030 Digit 1 shows 7'b1111111 (macro undefined) -> value nibble1=0, err_mask=4'b0010; with macro -> err_mask=0, blank_mask=4'b0010.
REQ-031 Digit 2 pattern glitches every 3 cycles, STABLE_CYCLES=4 -> digit 2 never captured, busy=1, out_valid stays 0.
REQ-032 Frame complete, out_ready held 0 for 10 cycles while inputs change -> value unchanged; out_ready=1 -> out_valid falls next cycle, new frame collects.
REQ-033 dig_sel=4'b0110 stable 20 cycles -> no capture, busy=0.
REQ-034 resetn pulsed low after 2 digits captured -> all outputs 0 immediately, following frame needs all 4 digits.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment reader: hex segment patterns (g..a, active-low)
// and the frame FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/seg_to_nibble.sv
// Combinational inverse of the hex segment table. SEG_READER_BLANK_EN makes the
// all-off pattern a valid blank instead of an error.
module seg_to_nibble
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid,
    output logic       blank
);

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        blank   = 1'b0;
        case (pattern)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
`ifdef SEG_READER_BLANK_EN
            SEG_BLANK: blank = 1'b1;
`endif
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Captures a multiplexed seven-segment display into a frame of nibbles once each digit has
// been stable long enough. Optional blank_mask output with SEG_READER_BLANK_EN.
module seg_reader
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  out_valid,
    output logic                  busy
`ifdef SEG_READER_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_mask
`endif
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

    state_e            state_q;
    logic [6:0]        seg_q, seg_prev;
    logic [DIGITS-1:0] sel_q, sel_prev;
    logic [DIGITS-1:0] capt_q;
    logic [7:0]        cnt_q;

    logic [3:0] dec_nibble;
    logic       dec_invalid;
    logic       dec_blank;

    seg_to_nibble u_dec (
        .pattern (seg_q),
        .nibble  (dec_nibble),
        .invalid (dec_invalid),
        .blank   (dec_blank)
    );

`ifndef SEG_READER_BLANK_EN
    logic unused_blank;
    assign unused_blank = dec_blank;
`endif

    logic       sel_ok;
    logic       same;
    logic [7:0] cnt_next;
    logic       capture;

    // Capture fires on the sample that brings the run of identical samples to STABLE_CYCLES.
    always_comb begin
        sel_ok   = $onehot(sel_q);
        same     = (seg_q == seg_prev) && (sel_q == sel_prev);
        cnt_next = 8'd0;
        if (same && sel_ok) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end
        capture = sel_ok && (cnt_next == CNT_HIT) && ((capt_q & sel_q) == '0);
    end

    assign busy = (state_q == COLLECT) && (capt_q != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= COLLECT;
            seg_q      <= '0;
            seg_prev   <= '0;
            sel_q      <= '0;
            sel_prev   <= '0;
            capt_q     <= '0;
            cnt_q      <= '0;
            value      <= '0;
            err_mask   <= '0;
            out_valid  <= 1'b0;
`ifdef SEG_READER_BLANK_EN
            blank_mask <= '0;
`endif
        end else begin
            seg_q    <= seg_in;
            seg_prev <= seg_q;
            sel_q    <= dig_sel;
            sel_prev <= sel_q;
            case (state_q)
                COLLECT: begin
                    if (&capt_q) begin
                        state_q   <= PRESENT;
                        out_valid <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_next;
                        for (int i = 0; i < int'(DIGITS); i++) begin
                            if (capture && sel_q[i]) begin
                                value[4*i +: 4] <= dec_nibble;
                                err_mask[i]     <= dec_invalid;
                                capt_q[i]       <= 1'b1;
`ifdef SEG_READER_BLANK_EN
                                blank_mask[i]   <= dec_blank;
`endif
                            end
                        end
                    end
                end
                PRESENT: begin
                    cnt_q <= '0;
                    if (out_ready) begin
                        state_q   <= COLLECT;
                        out_valid <= 1'b0;
                        capt_q    <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader (DIGITS=4, STABLE_CYCLES=4); honours SEG_READER_BLANK_EN.
module tb_seg_reader;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic [15:0] value;
    logic [3:0]  err_mask;
    logic        out_valid;
    logic        busy;
`ifdef SEG_READER_BLANK_EN
    logic [3:0]  blank_mask;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    seg_reader #(
        .DIGITS        (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .out_ready  (out_ready),
        .value      (value),
        .err_mask   (err_mask),
        .out_valid  (out_valid),
        .busy       (busy)
`ifdef SEG_READER_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int cycles);
        seg_in  = pat;
        dig_sel = 4'(1 << idx);
        repeat (cycles) tick();
    endtask

    task automatic ack();
        out_ready = 1'b1;
        dig_sel   = 4'b0000;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (value !== 16'h0000 || err_mask !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_data: value=%h err=%b required 0000/0000", value, err_mask);
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: valid=%b busy=%b required 0/0", out_valid, busy);
        end
`ifdef SEG_READER_BLANK_EN
        tests_run++;
        if (blank_mask !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_blank: blank=%b required 0000", blank_mask);
        end
`endif
        resetn = 1'b1;
        tick();
    endtask

    // 3,A,7,F for 6 cycles each: last digit captured on cycle 23, out_valid on cycle 24.
    task automatic test_scan();
        show(0, HEX[3], 6);
        show(1, HEX[10], 6);
        show(2, HEX[7], 6);
        show(3, HEX[15], 5);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_pre: valid=%b busy=%b required 0/1", out_valid, busy);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || value !== 16'hF7A3 || err_mask !== 4'h0) begin
            tests_failed++;
            $display("FAIL scan_frame: valid=%b value=%h err=%b required 1/f7a3/0000",
                     out_valid, value, err_mask);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            seg_in  = HEX[i];
            dig_sel = 4'(1 << (i % 4));
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || value !== 16'hF7A3 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: valid=%b value=%h busy=%b required 1/f7a3/0",
                         i, out_valid, value, busy);
            end
        end
        ack();
        tests_run++;
        if (out_valid !== 1'b0 || value !== 16'hF7A3) begin
            tests_failed++;
            $display("FAIL hold_release: valid=%b value=%h required 0/f7a3", out_valid, value);
        end
        show(0, HEX[1], 6);
        show(1, HEX[2], 6);
        show(2, HEX[3], 6);
        show(3, HEX[4], 6);
        tests_run++;
        if (out_valid !== 1'b1 || value !== 16'h4321 || err_mask !== 4'h0) begin
            tests_failed++;
            $display("FAIL hold_next: valid=%b value=%h err=%b required 1/4321/0000",
                     out_valid, value, err_mask);
        end
        ack();
    endtask

    task automatic test_blank();
        show(0, HEX[5], 6);
        show(1, BLANK, 6);
        show(2, HEX[0], 6);
        show(3, HEX[12], 6);
        tests_run++;
        if (out_valid !== 1'b1 || value !== 16'hC005) begin
            tests_failed++;
            $display("FAIL blank_value: valid=%b value=%h required 1/c005", out_valid, value);
        end
`ifdef SEG_READER_BLANK_EN
        tests_run++;
        if (err_mask !== 4'b0000 || blank_mask !== 4'b0010) begin
            tests_failed++;
            $display("FAIL blank_masks: err=%b blank=%b required 0000/0010",
                     err_mask, blank_mask);
        end
`else
        tests_run++;
        if (err_mask !== 4'b0010) begin
            tests_failed++;
            $display("FAIL blank_err: err=%b required 0010", err_mask);
        end
`endif
        ack();
    endtask

    // Digit 2 alternates 8/9 every 3 cycles, one short of the 4-sample requirement.
    task automatic test_glitch();
        show(0, HEX[1], 6);
        show(1, HEX[2], 6);
        for (int k = 0; k < 6; k++) show(2, (k % 2 == 1) ? HEX[9] : HEX[8], 3);
        show(3, HEX[13], 6);
        dig_sel = 4'b0000;
        repeat (5) tick();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_block: valid=%b busy=%b required 0/1", out_valid, busy);
        end
        show(2, HEX[14], 6);
        tests_run++;
        if (out_valid !== 1'b1 || value !== 16'hDE21) begin
            tests_failed++;
            $display("FAIL glitch_done: valid=%b value=%h required 1/de21", out_valid, value);
        end
        ack();
    endtask

    task automatic test_multihot();
        seg_in  = HEX[8];
        dig_sel = 4'b0110;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) begin
                tests_run++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL multihot_%0d: busy=%b valid=%b required 0/0",
                             i, busy, out_valid);
                end
            end
        end
        show(0, HEX[9], 6);
        show(1, HEX[8], 6);
        show(2, HEX[7], 6);
        show(3, HEX[6], 6);
        tests_run++;
        if (out_valid !== 1'b1 || value !== 16'h6789) begin
            tests_failed++;
            $display("FAIL multihot_frame: valid=%b value=%h required 1/6789", out_valid, value);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        bit ok;
        show(0, HEX[10], 6);
        show(1, HEX[11], 6);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_busy: busy=%b required 1", busy);
        end
        resetn = 1'b0;
        #1;
        tests_run++;
        if (value !== 16'h0000 || err_mask !== 4'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: value=%h err=%b valid=%b busy=%b required 0/0/0/0",
                     value, err_mask, out_valid, busy);
        end
        tick();
        resetn = 1'b1;
        show(2, HEX[4], 6);
        show(3, HEX[5], 6);
        dig_sel = 4'b0000;
        repeat (6) tick();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_partial: valid=%b busy=%b required 0/1", out_valid, busy);
        end
        show(0, HEX[6], 6);
        show(1, HEX[7], 1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (out_valid === 1'b1) ok = 1'b1;
        end
        tests_run++;
        if (!ok || value !== 16'h5476) begin
            tests_failed++;
            $display("FAIL midreset_frame: seen_valid=%b value=%h required 1/5476", ok, value);
        end
        ack();
    endtask

    initial begin
        resetn    = 1'b0;
        seg_in    = BLANK;
        dig_sel   = 4'b0000;
        out_ready = 1'b0;
        test_reset();
        test_scan();
        test_hold();
        test_blank();
        test_glitch();
        test_multihot();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
